// File: rtl/sprite_scaler_stream.sv
// Sprite source for the display path: streams one ROM sprite (or a solid background)
// upscaled by pixel and row replication over a valid/ready pixel interface.
module sprite_scaler_stream #(
  parameter int SRC_W = 80,
  parameter int SRC_H = 80,
  parameter int SCALE = 3,
  parameter int PIXEL_SIZE = 16,
  parameter int NUM_SPRITES = 5,
  parameter int ADDR_W = $clog2(NUM_SPRITES * SRC_W * SRC_H),
  parameter int SEL_W = 3,
  parameter logic [PIXEL_SIZE-1:0] BG_COLOR = 16'h001F
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  mirror,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [PIXEL_SIZE-1:0] mem_data,
  output logic [PIXEL_SIZE-1:0] pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  pix_sof,
  output logic                  pix_eol,
  output logic                  busy,
  output logic                  frame_done
);
  localparam int SPRITE_WORDS = SRC_W * SRC_H;
  localparam int HW = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int XW = (SRC_W > 1) ? $clog2(SRC_W) : 1;
  localparam int YW = (SRC_H > 1) ? $clog2(SRC_H) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_CAPTURE = 3'd2,
    S_STREAM  = 3'd3,
    S_FILL    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t            state_r, state_nx_s;
  logic              mirror_r;
  logic [ADDR_W-1:0] base_r, row_off_r, row_off_nx_s, start_base_s;
  logic [HW-1:0]     hx_r, hx_nx_s, vy_r, vy_nx_s;
  logic [XW-1:0]     x_r, x_nx_s;
  logic [YW-1:0]     y_r, y_nx_s;
  logic              beat_s, start_bg_s;
  logic              last_hx_s, last_x_s, last_vy_s, last_y_s, frame_last_s;

  // x is the logical column; mirroring only changes which ROM word it maps to.
  function automatic logic [ADDR_W-1:0] addr_f(input logic [ADDR_W-1:0] base,
                                               input logic [ADDR_W-1:0] row_off,
                                               input logic [XW-1:0] x, input logic mir);
    logic [ADDR_W-1:0] col;
    if (mir) col = ADDR_W'(SRC_W - 1) - ADDR_W'(x);
    else     col = ADDR_W'(x);
    return base + row_off + col;
  endfunction

  function automatic logic eol_f(input logic [HW-1:0] hx, input logic [XW-1:0] x);
    return (hx == HW'(SCALE - 1)) && (x == XW'(SRC_W - 1));
  endfunction

  function automatic logic sof_f(input logic [HW-1:0] hx, input logic [XW-1:0] x,
                                 input logic [HW-1:0] vy, input logic [YW-1:0] y);
    return (hx == HW'(0)) && (x == XW'(0)) && (vy == HW'(0)) && (y == YW'(0));
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= S_IDLE;
    else      state_r <= state_nx_s;
  end

  // Beat acceptance and the next position in the replicated raster.
  always_comb begin
    beat_s       = pix_valid && pix_ready && ((state_r == S_STREAM) || (state_r == S_FILL));
    last_hx_s    = (hx_r == HW'(SCALE - 1));
    last_x_s     = (x_r == XW'(SRC_W - 1));
    last_vy_s    = (vy_r == HW'(SCALE - 1));
    last_y_s     = (y_r == YW'(SRC_H - 1));
    frame_last_s = last_hx_s && last_x_s && last_vy_s && last_y_s;
    start_bg_s   = (int'(sel) >= NUM_SPRITES);
    start_base_s = ADDR_W'(sel) * ADDR_W'(SPRITE_WORDS);
    hx_nx_s      = hx_r;
    x_nx_s       = x_r;
    vy_nx_s      = vy_r;
    y_nx_s       = y_r;
    row_off_nx_s = row_off_r;
    if (last_hx_s) begin
      hx_nx_s = HW'(0);
      if (last_x_s) begin
        x_nx_s = XW'(0);
        if (last_vy_s) begin
          vy_nx_s = HW'(0);
          if (last_y_s) begin
            y_nx_s       = YW'(0);
            row_off_nx_s = ADDR_W'(0);
          end else begin
            y_nx_s       = y_r + YW'(1);
            row_off_nx_s = row_off_r + ADDR_W'(SRC_W);
          end
        end else begin
          vy_nx_s = vy_r + HW'(1);
        end
      end else begin
        x_nx_s = x_r + XW'(1);
      end
    end else begin
      hx_nx_s = hx_r + HW'(1);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_nx_s = start_bg_s ? S_FILL : S_LOAD;
        else       state_nx_s = S_IDLE;
      end
      S_LOAD:    state_nx_s = S_CAPTURE;
      S_CAPTURE: state_nx_s = S_STREAM;
      S_STREAM: begin
        if (beat_s && last_hx_s) state_nx_s = frame_last_s ? S_DONE : S_LOAD;
        else                     state_nx_s = S_STREAM;
      end
      S_FILL: begin
        if (beat_s && frame_last_s) state_nx_s = S_DONE;
        else                        state_nx_s = S_FILL;
      end
      S_DONE:  state_nx_s = S_IDLE;
      default: state_nx_s = S_IDLE;
    endcase
  end

  // Registered outputs, raster counters and per-frame latches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr   <= ADDR_W'(0);
      pix_data   <= PIXEL_SIZE'(0);
      pix_valid  <= 1'b0;
      pix_sof    <= 1'b0;
      pix_eol    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      mirror_r   <= 1'b0;
      base_r     <= ADDR_W'(0);
      row_off_r  <= ADDR_W'(0);
      hx_r       <= HW'(0);
      x_r        <= XW'(0);
      vy_r       <= HW'(0);
      y_r        <= YW'(0);
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            mirror_r  <= mirror;
            base_r    <= start_base_s;
            row_off_r <= ADDR_W'(0);
            hx_r      <= HW'(0);
            x_r       <= XW'(0);
            vy_r      <= HW'(0);
            y_r       <= YW'(0);
            if (start_bg_s) begin
              pix_data  <= BG_COLOR;
              pix_valid <= 1'b1;
              pix_sof   <= 1'b1;
              pix_eol   <= eol_f(HW'(0), XW'(0));
            end else begin
              mem_addr <= addr_f(start_base_s, ADDR_W'(0), XW'(0), mirror);
            end
          end
        end
        S_CAPTURE: begin
          pix_data  <= mem_data;
          pix_valid <= 1'b1;
          pix_sof   <= sof_f(hx_r, x_r, vy_r, y_r);
          pix_eol   <= eol_f(hx_r, x_r);
        end
        S_STREAM, S_FILL: begin
          if (beat_s) begin
            hx_r      <= hx_nx_s;
            x_r       <= x_nx_s;
            vy_r      <= vy_nx_s;
            y_r       <= y_nx_s;
            row_off_r <= row_off_nx_s;
            if (frame_last_s || (state_r == S_STREAM && last_hx_s)) begin
              pix_valid  <= 1'b0;
              pix_sof    <= 1'b0;
              pix_eol    <= 1'b0;
              frame_done <= frame_last_s;
              if (!frame_last_s) mem_addr <= addr_f(base_r, row_off_nx_s, x_nx_s, mirror_r);
            end else begin
              pix_sof <= sof_f(hx_nx_s, x_nx_s, vy_nx_s, y_nx_s);
              pix_eol <= eol_f(hx_nx_s, x_nx_s);
            end
          end
        end
        S_DONE: begin
          frame_done <= 1'b0;
          busy       <= 1'b0;
        end
        default: begin
          pix_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/sprite_scaler_stream.md
# sprite_scaler_stream

Parametrised pixel source for the ILI9341 display path: reads one of `NUM_SPRITES` equally sized sprites from a packed sprite ROM, upscales it by an integer factor through pixel and row replication, and delivers the result as a valid/ready pixel stream to the display controller. It adds several features:
- run-time sprite selection, latched at frame start;
- optional horizontal mirroring;
- a background-fill mode;
- backpressure tolerance.

It sits between the sprite ROM and the controller's pixel input, inside the display top level.

## Interface
- `SRC_W`, 80, source sprite width in pixels.
- `SRC_H`, 80, source sprite height in pixels.
- `SCALE`, 3, integer upscale factor (≥1). Derived values: `DST_W = SRC_W*SCALE`, `DST_H = SRC_H*SCALE`.
- `PIXEL_SIZE`, 16, pixel width (RGB565).
- `NUM_SPRITES`, 5, number of sprites in the ROM, packed back to back. Sprite `s` base address is `s*SRC_W*SRC_H`.
- `ADDR_W`, `$clog2(NUM_SPRITES*SRC_W*SRC_H)`, ROM address width.
- `SEL_W`, 3, width of the sprite selector.
- `BG_COLOR`, 16'h001F, fill colour in background mode.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  frame request; sampled only in IDLE.
- `sel`  in  SEL_W  sprite index, latched on accepted `start`. Values ≥ `NUM_SPRITES` select background mode.
- `mirror`  in  1  horizontal flip, latched on accepted `start`.
- `mem_addr`  out  ADDR_W  registered ROM address.
- `mem_data`  in  PIXEL_SIZE  ROM read data, valid one cycle after `mem_addr`.
- `pix_data`  out  PIXEL_SIZE  output pixel.
- `pix_valid`  out  1  `pix_data` valid.
- `pix_ready`  in  1  sink accepts the beat when `pix_valid && pix_ready`.
- `pix_sof`  out  1  high with the first beat of the frame.
- `pix_eol`  out  1  high with the last beat of each destination row.
- `busy`  out  1  high from accepted `start` until `frame_done`.
- `frame_done`  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- States: IDLE, LOAD, CAPTURE, STREAM, FILL, DONE.
- IDLE: when `start` is high, latch `sel` and `mirror` and clear all counters.
  - Background mode (latched `sel` ≥ `NUM_SPRITES`): go to FILL.
  - Otherwise: set `mem_addr` to the first address and go to LOAD.
- LOAD: the ROM address is stable for one cycle. Go to CAPTURE.
- CAPTURE: `pix_data<=mem_data`, `pix_valid<=1`. Go to STREAM.
- STREAM: hold the same pixel for `SCALE` accepted beats (horizontal replication count `hx`). After the last of these beats:
  - If the source row is not finished: advance the source column and go to LOAD with the new address.
  - End of a destination row: if the row-repeat count `vy < SCALE-1`, increment `vy` and restart the same source row. Otherwise clear `vy`, advance the source row and restart at column 0 (or `SRC_W-1` when mirrored).
  - Last beat of the last destination row: go to DONE.
- Address rule: `mem_addr = base + src_y*SRC_W + (mirror ? SRC_W-1-src_x : src_x)`.
  - Row offset is kept as an accumulator (add `SRC_W` per row).
  - No multipliers or dividers on the per-pixel path.
- FILL: `pix_data=BG_COLOR` and `pix_valid=1` continuously. Counts `DST_W*DST_H` accepted beats, then goes to DONE. No ROM access; `mem_addr` holds its value.
- DONE: `frame_done=1` for one cycle, `busy=0` next, return to IDLE.
- `pix_sof` is high on the beat where all counters are zero. `pix_eol` is high on the beat where the destination column is `DST_W-1`.
- Beat count per frame is exactly `DST_W*DST_H` in both modes.

## Timing
- Reset values: `mem_addr=0`, `pix_data=0`, `pix_valid=0`, `pix_sof=0`, `pix_eol=0`, `busy=0`, `frame_done=0`, state IDLE.
- Reset asserted mid-frame aborts immediately. After reset is released, the block waits in IDLE.
- Sprite mode latency: `start` sampled at edge 0 → LOAD in cycle 1 → CAPTURE in cycle 2 → `pix_valid` high from cycle 3.
- After the last replicated beat of a source pixel there is a 2-cycle bubble (LOAD, CAPTURE) before the next pixel. Peak throughput is `SCALE/(SCALE+2)`.
- Background mode: `pix_valid` high from cycle 1, one beat per cycle while `pix_ready` is high.
- While `pix_valid && !pix_ready`: `pix_data`, `pix_sof`, `pix_eol` and all counters hold. `pix_valid` never drops before acceptance.
- `frame_done` pulses in the cycle after the final accepted beat. `start` is accepted no earlier than the following cycle, i.e. in IDLE.
- `start` while `busy` is ignored. Changing `sel` or `mirror` mid-frame has no effect on the current frame.
- `SCALE=1`: each source pixel is emitted once and `vy` never increments.

## Test plan
- Test configuration: `SRC_W=4`, `SRC_H=2`, `SCALE=2`, ROM word = address. `sel=1`, `pix_ready=1` → 32 beats; row 0 = 8,8,9,9,10,10,11,11; rows 0–1 identical; rows 2–3 = 12..15 doubled. `pix_sof` on beat 0, `pix_eol` on beats 7, 15, 23, 31, single `frame_done`.
- Same configuration with `mirror=1`, `sel=0` → row 0 = 3,3,2,2,1,1,0,0. First `pix_valid` exactly 3 cycles after `start`.
- `sel=7` → 32 beats of 16'h001F on consecutive cycles, `mem_addr` constant, `frame_done` one cycle after beat 31.
- Random `pix_ready` deassertion (about 50%) → beat sequence identical to the first scenario, `pix_data` stable while stalled.
- `start` pulsed and `sel` changed mid-frame → ignored, frame completes with the original sprite. Reset asserted at beat 10 → all outputs 0 immediately, next `start` restarts from beat 0.
- Default parameters, `sel=4` → 57600 beats. First beat address 25600, last beat address 31999.
